// File: rtl/mult32x32_fast_ctrl_if.sv
// mult32x32_fast_ctrl_if
//  Control/status bundle between the fast multiplier control FSM and the
//  surrounding arithmetic datapath.
//  start       request a multiply (top level -> controller)
//  a_msb_is_0  A[31:24]==0 flag from the arith unit
//  b_msw_is_0  B[31:16]==0 flag from the arith unit
//  busy        controller is in an accumulate step
//  done        one-cycle pulse, product register holds the final result
//  a_sel       A byte select (0..3)
//  b_sel       B word select (0..1)
//  shift_sel   partial product shift, 8*shift_sel bits (0..5)
//  upd_prod    accumulate the shifted partial product
//  clr_prod    clear the product register
//  Modports: slave = controller side, master = datapath/top side.
interface mult32x32_fast_ctrl_if;
  logic       start;
  logic       a_msb_is_0;
  logic       b_msw_is_0;
  logic       busy;
  logic       done;
  logic [1:0] a_sel;
  logic       b_sel;
  logic [2:0] shift_sel;
  logic       upd_prod;
  logic       clr_prod;

  modport slave (
    input  start, a_msb_is_0, b_msw_is_0,
    output busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod
  );

  modport master (
    output start, a_msb_is_0, b_msw_is_0,
    input  busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod
  );
endinterface

// File: rtl/mult32x32_fast_ctrl.sv
// mult32x32_fast_ctrl
//  Control FSM for the 32x32 fast multiplier. A start clears the product
//  register, then the eight 8x16 partial products (A byte i times B word j,
//  shifted by 8*(i+2j)) are accumulated one per cycle. With SKIP_EN set,
//  steps whose operand part is known to be zero are skipped.
//  Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (aborts any run, no done)
//   ctrl   slave side of mult32x32_fast_ctrl_if (start/flags in,
//          busy/done/selects/update/clear out)
module mult32x32_fast_ctrl #(
  parameter bit SKIP_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  mult32x32_fast_ctrl_if.slave          ctrl
);

  // Step states are encoded as 1 + (i + 4*j), so state-1 directly gives
  // the (j,i) pair in bits [2] and [1:0].
  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] A0B0 = 4'd1;
  localparam logic [3:0] A1B0 = 4'd2;
  localparam logic [3:0] A2B0 = 4'd3;
  localparam logic [3:0] A3B0 = 4'd4;
  localparam logic [3:0] A0B1 = 4'd5;
  localparam logic [3:0] A1B1 = 4'd6;
  localparam logic [3:0] A2B1 = 4'd7;
  localparam logic [3:0] A3B1 = 4'd8;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       done_q;
  logic       in_step;
  logic [2:0] step_idx;

  assign in_step  = (state != IDLE);
  assign step_idx = 3'(state - A0B0);

  // A step is skipped when its A byte is the zero MSB or its B word is the
  // zero MSW.
  function automatic logic step_skipped(input logic [2:0] k,
                                        input logic       a_zero,
                                        input logic       b_zero);
    return SKIP_EN && (((k[1:0] == 2'd3) && a_zero) || (k[2] && b_zero));
  endfunction

  // Next state: from IDLE go to A0B0 on start; from a step go to the
  // nearest later step that is not skipped, else back to IDLE. The loop
  // runs downward so the last assignment wins with the nearest candidate.
  always_comb begin
    next_state = IDLE;
    if (!in_step) begin
      if (ctrl.start)
        next_state = A0B0;
    end else begin
      for (int k = 7; k >= 1; k--) begin
        if ((k > int'(step_idx)) &&
            !step_skipped(3'(k), ctrl.a_msb_is_0, ctrl.b_msw_is_0))
          next_state = 4'(k + 1);
      end
    end
  end

  // done is the registered "this was the last step" flag, so it rises in
  // the cycle the FSM is back in IDLE and can already accept a new start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= in_step && (next_state == IDLE);
    end
  end

  assign ctrl.busy      = in_step;
  assign ctrl.upd_prod  = in_step;
  assign ctrl.done      = done_q;
  assign ctrl.a_sel     = in_step ? step_idx[1:0] : 2'd0;
  assign ctrl.b_sel     = in_step ? step_idx[2] : 1'b0;
  assign ctrl.shift_sel = in_step ? ({1'b0, step_idx[1:0]} + {1'b0, step_idx[2], 1'b0})
                                  : 3'd0;
  // Clearing is held off during reset so the product stays at its reset value.
  assign ctrl.clr_prod  = !in_step && ctrl.start && !reset;

endmodule

// File: tb/tb_mult32x32_fast_ctrl.sv
// tb_mult32x32_fast_ctrl
//  Self-checking bench for mult32x32_fast_ctrl. Two instances are built,
//  one with skipping enabled and one without. A small product register model
//  follows each controller's select/update/clear outputs, and a scoreboard
//  holds the expected step sequence and final product of every multiply.
//  No ports.
module tb_mult32x32_fast_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [31:0] op_a, op_b;
  logic [63:0] prod0, prod1;

  int compared   = 0;
  int mismatched = 0;

  logic [5:0]  step_q0[$];
  logic [5:0]  step_q1[$];
  logic [63:0] prod_q0[$];
  logic [63:0] prod_q1[$];

  mult32x32_fast_ctrl_if if0 ();
  mult32x32_fast_ctrl_if if1 ();

  assign if0.start      = start0;
  assign if0.a_msb_is_0 = (op_a[31:24] == 8'd0);
  assign if0.b_msw_is_0 = (op_b[31:16] == 16'd0);
  assign if1.start      = start1;
  assign if1.a_msb_is_0 = (op_a[31:24] == 8'd0);
  assign if1.b_msw_is_0 = (op_b[31:16] == 16'd0);

  mult32x32_fast_ctrl #(.SKIP_EN(1'b1)) dut_skip (.clk(clk), .reset(reset), .ctrl(if0));
  mult32x32_fast_ctrl #(.SKIP_EN(1'b0)) dut_full (.clk(clk), .reset(reset), .ctrl(if1));

  always #5 clk = ~clk;

  // Partial product as the arith unit would form it from the selects.
  function automatic logic [63:0] pp(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] as, input logic bs,
                                     input logic [2:0] ss);
    logic [31:0] ash;
    logic [31:0] bsh;
    logic [63:0] pv;
    ash = a >> (8 * as);
    bsh = b >> (16 * bs);
    pv  = {56'd0, ash[7:0]} * {48'd0, bsh[15:0]};
    return pv << (8 * ss);
  endfunction

  // Product register models driven by each controller.
  always @(posedge clk or posedge reset) begin
    if (reset)              prod0 <= 64'd0;
    else if (if0.clr_prod)  prod0 <= 64'd0;
    else if (if0.upd_prod)  prod0 <= prod0 + pp(op_a, op_b, if0.a_sel, if0.b_sel, if0.shift_sel);
  end

  always @(posedge clk or posedge reset) begin
    if (reset)              prod1 <= 64'd0;
    else if (if1.clr_prod)  prod1 <= 64'd0;
    else if (if1.upd_prod)  prod1 <= prod1 + pp(op_a, op_b, if1.a_sel, if1.b_sel, if1.shift_sel);
  end

  // Advance to the next falling edge and retire scoreboard entries for any
  // step or done visible on either controller.
  task automatic tick();
    logic       upd, dn, empty;
    logic [5:0] got, exp;
    logic [63:0] pv, pexp;
    @(negedge clk);
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        upd = (d == 0) ? if0.upd_prod : if1.upd_prod;
        dn  = (d == 0) ? if0.done : if1.done;
        got = (d == 0) ? {if0.a_sel, if0.b_sel, if0.shift_sel}
                       : {if1.a_sel, if1.b_sel, if1.shift_sel};
        pv  = (d == 0) ? prod0 : prod1;
        if (upd) begin
          compared++;
          empty = (d == 0) ? (step_q0.size() == 0) : (step_q1.size() == 0);
          if (empty) begin
            mismatched++;
            $display("[TB] FAIL sb_step dut%0d: unexpected step sel=%h, required no step", d, got);
          end else begin
            exp = (d == 0) ? step_q0.pop_front() : step_q1.pop_front();
            if (got !== exp) begin
              mismatched++;
              $display("[TB] FAIL sb_step dut%0d: {a_sel,b_sel,shift_sel} got %h required %h", d, got, exp);
            end
          end
        end
        if (dn) begin
          compared++;
          empty = (d == 0) ? (prod_q0.size() == 0) : (prod_q1.size() == 0);
          if (empty) begin
            mismatched++;
            $display("[TB] FAIL sb_done dut%0d: unexpected done, product %h", d, pv);
          end else begin
            pexp = (d == 0) ? prod_q0.pop_front() : prod_q1.pop_front();
            if (pv !== pexp) begin
              mismatched++;
              $display("[TB] FAIL sb_product dut%0d: got %h required %h", d, pv, pexp);
            end
          end
        end
      end
    end
  endtask

  // Queue the expected steps (fixed order, skip rules) and product.
  task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                         input bit on1, output int n);
    bit skip;
    n = 0;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) begin
        skip = !on1 && (((i == 3) && (a[31:24] == 8'd0)) || ((j == 1) && (b[31:16] == 16'd0)));
        if (!skip) begin
          n++;
          if (on1) step_q1.push_back({2'(i), 1'(j), 3'(i + 2 * j)});
          else     step_q0.push_back({2'(i), 1'(j), 3'(i + 2 * j)});
        end
      end
    end
    if (on1) prod_q1.push_back({32'd0, a} * {32'd0, b});
    else     prod_q0.push_back({32'd0, a} * {32'd0, b});
  endtask

  task automatic set_start(input bit on1, input logic v);
    if (on1) start1 = v;
    else     start0 = v;
  endtask

  // One multiply: start pulse, optional stray start at cycle pulse_at,
  // wait for done. Returns busy cycles and the done cycle relative to T.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit on1,
                        input int pulse_at, input string name,
                        output int busy_cnt, output int done_cyc);
    int  n;
    logic bsy, dn, clr;
    op_a = a;
    op_b = b;
    push_op(a, b, on1, n);
    busy_cnt = 0;
    done_cyc = 0;
    tick();
    set_start(on1, 1'b1);
    #1;
    clr = on1 ? if1.clr_prod : if0.clr_prod;
    compared++;
    if (clr !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL %s_clr_on_start: clr_prod got %b required 1", name, clr);
    end
    tick();
    set_start(on1, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) tick();
      if (c == pulse_at + 1) set_start(on1, 1'b0);
      if (c == pulse_at) begin
        set_start(on1, 1'b1);
        #1;
        clr = on1 ? if1.clr_prod : if0.clr_prod;
        compared++;
        if (clr !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL %s_clr_while_busy: clr_prod got %b required 0", name, clr);
        end
      end
      bsy = on1 ? if1.busy : if0.busy;
      dn  = on1 ? if1.done : if0.done;
      if (dn) begin
        done_cyc = c;
        compared++;
        if (bsy !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL %s_busy_at_done: busy got %b required 0", name, bsy);
        end
        break;
      end
      if (bsy) busy_cnt++;
    end
    set_start(on1, 1'b0);
    compared++;
    if (done_cyc != n + 1) begin
      mismatched++;
      $display("[TB] FAIL %s_done_latency: done at T+%0d required T+%0d", name, done_cyc, n + 1);
    end
    compared++;
    if ((on1 ? step_q1.size() : step_q0.size()) != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_steps_left: %0d expected steps not executed, required 0", name,
               on1 ? step_q1.size() : step_q0.size());
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start0 = 1'b1;
    start1 = 1'b0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    @(negedge clk);
    #1;
    compared++;
    if ({if0.busy, if0.done, if0.upd_prod, if0.clr_prod, if0.a_sel, if0.b_sel, if0.shift_sel} !== 10'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b required all 0",
               {if0.busy, if0.done, if0.upd_prod, if0.clr_prod, if0.a_sel, if0.b_sel, if0.shift_sel});
    end
    start0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    compared++;
    if ({if1.busy, if1.done, if1.upd_prod, if1.clr_prod} !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: got %b required 0000", {if1.busy, if1.done, if1.upd_prod, if1.clr_prod});
    end
  endtask

  task automatic test_full_operands();
    int bc, dc;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "full", bc, dc);
    compared++;
    if (bc != 8 || dc != 9) begin
      mismatched++;
      $display("[TB] FAIL full_count: busy %0d done T+%0d required 8 / T+9", bc, dc);
    end
    compared++;
    if (prod0 !== 64'hFFFF_FFFE_0000_0001) begin
      mismatched++;
      $display("[TB] FAIL full_product: got %h required fffffffe00000001", prod0);
    end
  endtask

  task automatic test_both_zero();
    int bc, dc;
    run_op(32'h00FF_FFFF, 32'h0000_FFFF, 1'b0, 0, "both_zero", bc, dc);
    compared++;
    if (bc != 3 || dc != 4) begin
      mismatched++;
      $display("[TB] FAIL both_zero_count: busy %0d done T+%0d required 3 / T+4", bc, dc);
    end
    compared++;
    if (prod0 !== 64'h0000_00FF_FEFF_0001) begin
      mismatched++;
      $display("[TB] FAIL both_zero_product: got %h required 000000fffeff0001", prod0);
    end
  endtask

  task automatic test_a_msb_zero();
    int bc, dc;
    run_op(32'h0000_0002, 32'h0003_0000, 1'b0, 0, "a_msb_zero", bc, dc);
    compared++;
    if (bc != 6 || prod0 !== 64'h0000_0000_0006_0000) begin
      mismatched++;
      $display("[TB] FAIL a_msb_zero: busy %0d product %h required 6 / 0000000000060000", bc, prod0);
    end
  endtask

  task automatic test_no_skip();
    int bc, dc;
    run_op(32'h00FF_FFFF, 32'h0000_FFFF, 1'b1, 0, "no_skip", bc, dc);
    compared++;
    if (bc != 8 || dc != 9 || prod1 !== 64'h0000_00FF_FEFF_0001) begin
      mismatched++;
      $display("[TB] FAIL no_skip: busy %0d done T+%0d product %h required 8 / T+9 / 000000fffeff0001",
               bc, dc, prod1);
    end
  endtask

  task automatic test_start_while_busy();
    int bc, dc;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, "busy_start", bc, dc);
    compared++;
    if (bc != 8 || dc != 9) begin
      mismatched++;
      $display("[TB] FAIL busy_start_count: busy %0d done T+%0d required 8 / T+9", bc, dc);
    end
  endtask

  task automatic test_reset_abort();
    int n, dones;
    op_a = 32'hFFFF_FFFF;
    op_b = 32'hFFFF_FFFF;
    step_q0.push_back({2'd0, 1'b0, 3'd0});
    step_q0.push_back({2'd1, 1'b0, 3'd1});
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    compared++;
    if ({if0.busy, if0.upd_prod, if0.done, if0.a_sel, if0.shift_sel} !== 8'd0 || prod0 !== 64'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_abort: outputs %b product %h required 0 / 0",
               {if0.busy, if0.upd_prod, if0.done, if0.a_sel, if0.shift_sel}, prod0);
    end
    tick();
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (if0.done) dones++;
    end
    compared++;
    if (dones != 0 || step_q0.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL reset_abort_no_done: dones %0d steps left %0d required 0 / 0", dones, step_q0.size());
    end
    n = 0;
  endtask

  task automatic test_back_to_back();
    int n, first, second;
    op_a = 32'hFFFF_FFFF;
    op_b = 32'hFFFF_FFFF;
    push_op(op_a, op_b, 1'b0, n);
    push_op(op_a, op_b, 1'b0, n);
    first  = 0;
    second = 0;
    tick();
    start0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (if0.done) begin first = c; break; end
    end
    compared++;
    if (first != 9 || if0.clr_prod !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: done T+%0d clr_prod %b required T+9 / 1", first, if0.clr_prod);
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      start0 = 1'b0;
      if (c == 1) begin
        compared++;
        if (if0.busy !== 1'b1 || if0.shift_sel !== 3'd0) begin
          mismatched++;
          $display("[TB] FAIL b2b_restart: busy %b shift_sel %0d required 1 / 0", if0.busy, if0.shift_sel);
        end
      end
      if (if0.done) begin second = c; break; end
    end
    compared++;
    if (second != 9 || step_q0.size() != 0 || prod_q0.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: done %0d cycles later, queues %0d/%0d, required 9 / 0 / 0",
               second, step_q0.size(), prod_q0.size());
    end
  endtask

  task automatic test_random_ops();
    int bc, dc;
    logic [31:0] a, b;
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      b = $urandom;
      if (k[0])    a[31:24] = 8'd0;
      if (k[1])    b[31:16] = 16'd0;
      run_op(a, b, k[2], 0, "random", bc, dc);
    end
  endtask

  initial begin
    test_reset();
    test_full_operands();
    test_both_zero();
    test_a_msb_zero();
    test_no_skip();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    test_random_ops();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
